mul_seq64: RTL and testbench
============================

# mul_seq64

Multi-cycle unsigned 64x64 shift-add multiplier. It sits between the 32x64 register file's read ports and its write port. It takes operands from the A/B buses on a start pulse and iterates one partial product per clock. It then issues a single-cycle write of the selected product half back to the register file through the D/DA/W write port.

## Interface
Parameters:
- WIDTH, 64, operand and result width
- AW, 5, register address width

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op  in  1  0 = low half of product (MUL), 1 = high half, unsigned (UMULH)
- A  in  WIDTH  multiplicand, from register file A bus
- B  in  WIDTH  multiplier, from register file B bus
- DA_in  in  AW  destination register for the result
- D  out  WIDTH  write data to register file
- DA  out  AW  write address to register file
- W  out  1  write enable to register file; one-cycle pulse
- busy  out  1  high in RUN and WB

## Operation
- States:
  - IDLE: start=1 latches A→mcand, B into the low product half, hi=0, op, DA_in, count=0, and moves to RUN. start=0 stays in IDLE.
  - RUN: each cycle, {c,hi} = hi + (lo[0] ? mcand : 0), computed as a 65-bit sum. Then {c,hi,lo} shifts right by 1 and count increments. After the iteration with count=63, move to WB.
  - WB: W=1. D = op ? hi : lo. DA = latched destination. Move to IDLE.
- Arithmetic:
  - After 64 iterations, {hi,lo} is the full 128-bit unsigned product.
  - The low half is identical for signed operands. The high half is unsigned only.
- start in RUN or WB is ignored. There is no queuing, and the latched operands are not disturbed.
- Destination 31 is handled normally: W pulses and the register file discards the write (R31 reads zero).
- The A/B buses may change after the start cycle; only the values present in the start cycle are used.

## Timing
- Reset values:
  - state IDLE, busy 0, W 0, D 0, DA 0.
  - Internal product, mcand and count are all 0.
- Latency is fixed and data-independent. There is no early termination.
  - start high in cycle 0 (in IDLE) → busy high cycles 1–65, RUN cycles 1–64, W high in cycle 65 only.
  - IDLE resumes in cycle 66.
  - The earliest next accepted start is cycle 66; its W falls in cycle 131.
- D and DA are registered:
  - They update on entry to WB and hold their value until the next WB. D remains valid after W drops.
  - The register file captures D on the clock edge ending cycle 65.
- busy is combinational from state, not registered separately.
- Reset asserted mid-operation: on the next edge, return to IDLE with all outputs at reset values. No W pulse is produced for the aborted operation. start in the same cycle as reset is ignored.
- The block itself has no read-after-write hazard handling. The controller must not start an operation that depends on a pending result until busy=0.

## Test plan
- Reset and idle:
  - Assert reset for 2 cycles → busy=0, W=0, D=0, DA=0.
  - Hold start=0 for 100 cycles → W never pulses.
- Basic MUL:
  - A=7, B=6, op=0, DA_in=3, start in cycle 0 → W=1 only in cycle 65 with D=42, DA=3.
  - busy=1 over cycles 1–65.
- Full-width UMULH:
  - A=B=64'hFFFF_FFFF_FFFF_FFFF, op=1, DA_in=5 → D=64'hFFFF_FFFF_FFFF_FFFE.
  - The same operands with op=0 → D=64'h0000_0000_0000_0001.
- Busy ignore:
  - Start with A=3, B=5 (DA_in=1). Pulse start again in cycle 10 with A=9, B=9, DA_in=2.
  - → exactly one W pulse, in cycle 65, with D=15, DA=1. No second pulse occurs before cycle 131.
- Reset mid-operation:
  - Start with A=2, B=2. Assert reset in cycle 30.
  - → no W pulse; busy=0 from cycle 31.
  - A new start in cycle 40 (A=4, B=5) → D=20 with W in cycle 105.
- Random and back-to-back:
  - 200 random A/B/op pairs issued at cycle 66-multiples, checked against a 128-bit reference product.
  - Destination 31 included → each W pulse carries the correct half with a 65-cycle latency.

Source files
------------

// File: rtl/mul_seq64.sv
// mul_seq64: unsigned shift-add multiplier that reads two register-file
// operands, iterates one partial product per clock for WIDTH cycles, and then
// writes the selected half of the product back through a one-cycle write port.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for start; operands latched on the start cycle
// S_RUN  | one shift-add iteration per clock, count 0 .. WIDTH-1
// S_WB   | write-back cycle: W high, D/DA already hold the result
module mul_seq64 #(
    parameter int WIDTH = 64,
    parameter int AW    = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [AW-1:0]    DA_in,
    output logic [WIDTH-1:0] D,
    output logic [AW-1:0]    DA,
    output logic             W,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             op_q;
    logic [AW-1:0]    da_q;
    logic [CW-1:0]    count_q;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] hi_n;
    logic [WIDTH-1:0] lo_n;
    logic             last_iter;

    // One iteration: add the multiplicand when the current multiplier bit is
    // set, then shift {carry,hi,lo} right by one. The carry lands in hi's MSB.
    assign sum       = {1'b0, hi_q} + {1'b0, {WIDTH{lo_q[0]}} & mcand_q};
    assign hi_n      = sum[WIDTH:1];
    assign lo_n      = {sum[0], lo_q[WIDTH-1:1]};
    assign last_iter = (count_q == CW'(WIDTH - 1));

    assign busy = (state_q != S_IDLE);
    assign W    = (state_q == S_WB);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start outside IDLE is ignored
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_iter) state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand latch, iteration datapath and registered write-back outputs.
    // D/DA load on the final iteration so they are valid throughout WB and
    // hold afterwards until the next result.
    always_ff @(posedge clock) begin
        if (reset) begin
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            op_q    <= 1'b0;
            da_q    <= '0;
            count_q <= '0;
            D       <= '0;
            DA      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mcand_q <= A;
                        lo_q    <= B;
                        hi_q    <= '0;
                        op_q    <= op;
                        da_q    <= DA_in;
                        count_q <= '0;
                    end
                end
                S_RUN: begin
                    hi_q    <= hi_n;
                    lo_q    <= lo_n;
                    count_q <= count_q + CW'(1);
                    if (last_iter) begin
                        D  <= op_q ? hi_n : lo_n;
                        DA <= da_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq64.sv
// Self-checking bench for mul_seq64: directed cases plus randomized
// back-to-back operations compared against a 128-bit arithmetic reference.
module tb_mul_seq64;

    logic        clock;
    logic        reset;
    logic        start;
    logic        op;
    logic [63:0] A;
    logic [63:0] B;
    logic [4:0]  DA_in;
    logic [63:0] D;
    logic [4:0]  DA;
    logic        W;
    logic        busy;

    int total = 0;
    int bad   = 0;

    mul_seq64 #(.WIDTH(64), .AW(5)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .DA_in (DA_in),
        .D     (D),
        .DA    (DA),
        .W     (W),
        .busy  (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point for the whole bench
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_result(input logic [63:0] a, input logic [63:0] b,
                                               input logic o);
        logic [127:0] prod;
        prod = {64'd0, a} * {64'd0, b};
        return o ? prod[127:64] : prod[63:0];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Caller is positioned #1 after a rising edge; that clock period is cycle 0.
    // Runs for len cycles and returns positioned at cycle len.
    // restart_cyc > 0 pulses an extra (to-be-ignored) start in that cycle.
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic o, input logic [4:0] da, input int restart_cyc,
                          input int len);
        logic [63:0] exp;
        int          wn;
        int          wc;
        int          busy_bad;
        logic [63:0] dcap;
        logic [4:0]  dacap;
        exp      = ref_result(a, b, o);
        wn       = 0;
        wc       = -1;
        busy_bad = 0;
        dcap     = '0;
        dacap    = '0;
        chk({tag, "_idle_before"}, {127'd0, busy}, 128'd0);
        A     = a;
        B     = b;
        op    = o;
        DA_in = da;
        start = 1'b1;
        for (int k = 1; k <= len; k++) begin
            tick();
            start = (k == restart_cyc);
            A     = {$urandom, $urandom};
            B     = {$urandom, $urandom};
            op    = 1'($urandom);
            DA_in = 5'($urandom);
            if (W) begin
                wn++;
                if (wc < 0) begin
                    wc    = k;
                    dcap  = D;
                    dacap = DA;
                end
            end
            if (busy !== (k <= 65)) busy_bad++;
        end
        start = 1'b0;
        chk({tag, "_w_count"}, wn, 1);
        chk({tag, "_w_cycle"}, wc, 65);
        chk({tag, "_d"}, {64'd0, dcap}, {64'd0, exp});
        chk({tag, "_da"}, {123'd0, dacap}, {123'd0, da});
        chk({tag, "_busy"}, busy_bad, 0);
        chk({tag, "_d_hold"}, {64'd0, D}, {64'd0, exp});
    endtask

    initial begin
        int wn;
        int busy_bad;
        logic [63:0] ra;
        logic [63:0] rb;
        logic [4:0]  rd;

        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        A     = '0;
        B     = '0;
        DA_in = '0;

        tick();
        tick();
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_w", {127'd0, W}, 128'd0);
        chk("rst_d", {64'd0, D}, 128'd0);
        chk("rst_da", {123'd0, DA}, 128'd0);

        reset = 1'b0;
        wn = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (W) wn++;
        end
        chk("idle_no_w", wn, 0);

        run_op("mul_7x6", 64'd7, 64'd6, 1'b0, 5'd3, 0, 66);
        run_op("umulh_ones", '1, '1, 1'b1, 5'd5, 0, 66);
        chk("umulh_ones_val", {64'd0, D}, {64'd0, 64'hFFFF_FFFF_FFFF_FFFE});
        run_op("mul_ones", '1, '1, 1'b0, 5'd5, 0, 66);
        chk("mul_ones_val", {64'd0, D}, 128'd1);

        run_op("busy_ignore", 64'd3, 64'd5, 1'b0, 5'd1, 10, 130);

        // Reset in cycle 30 of an operation, new start in cycle 40
        A     = 64'd2;
        B     = 64'd2;
        op    = 1'b0;
        DA_in = 5'd7;
        start = 1'b1;
        wn       = 0;
        busy_bad = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            start = (k == 30);
            reset = (k == 30);
            if (W) wn++;
            if (k >= 31 && (busy !== 1'b0)) busy_bad++;
            if (k == 31) begin
                chk("rst_mid_d", {64'd0, D}, 128'd0);
                chk("rst_mid_da", {123'd0, DA}, 128'd0);
            end
        end
        chk("rst_mid_no_w", wn, 0);
        chk("rst_mid_busy", busy_bad, 0);
        run_op("after_rst", 64'd4, 64'd5, 1'b0, 5'd9, 0, 66);

        for (int i = 0; i < 200; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i % 17 == 0) ra = '1;
            if (i % 23 == 0) rb = 64'd0;
            rd = (i % 5 == 0) ? 5'd31 : 5'($urandom);
            run_op("rand", ra, rb, 1'($urandom), rd, 0, 66);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
